// File: rtl/sev_seg_scanner.sv
// Self-timed seven-segment bank scanner: owns the digit-scan counter, decodes hex nibbles,
// and drives registered anode/segment/dp pins with PWM brightness and leading-zero blanking.
module sev_seg_scanner #(
   parameter int NUM_DIGITS = 8,
   parameter int CLK_DIV    = 100000,
   parameter int BRIGHT_W   = 4,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [4*NUM_DIGITS-1:0]   data_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic [NUM_DIGITS-1:0]     digit_en,
   input  logic                      load,
   input  logic                      blank_lz,
   input  logic [BRIGHT_W-1:0]       brightness,
   output logic [NUM_DIGITS-1:0]     an_out,
   output logic [6:0]                seg_out,
   output logic                      dp_out,
   output logic                      frame_tick
);

   localparam int PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW   = $clog2(NUM_DIGITS);
   localparam int OW   = PW + 1;
   localparam int STEP = CLK_DIV >> BRIGHT_W;
   localparam logic POL = (ACTIVE_LOW != 0);

   logic [PW-1:0]             prescaler;
   logic [IW-1:0]             index;
   logic                      slot_end;
   logic                      frame_end;

   logic [4*NUM_DIGITS-1:0]   pending_data;
   logic [NUM_DIGITS-1:0]     pending_dp;
   logic [4*NUM_DIGITS-1:0]   active_data;
   logic [NUM_DIGITS-1:0]     active_dp;

   logic [3:0]                cur_nib;
   logic                      cur_dp;
   logic                      cur_en;
   logic                      cur_blank;
   logic [NUM_DIGITS-1:0]     lz_blank;
   logic                      zero_run;
   logic [OW-1:0]             on_limit;
   logic                      in_window;

   logic [NUM_DIGITS-1:0]     an_next;
   logic [6:0]                seg_next;
   logic                      dp_next;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      case (nib)
         4'h0:    hex7 = 7'h3F;
         4'h1:    hex7 = 7'h06;
         4'h2:    hex7 = 7'h5B;
         4'h3:    hex7 = 7'h4F;
         4'h4:    hex7 = 7'h66;
         4'h5:    hex7 = 7'h6D;
         4'h6:    hex7 = 7'h7D;
         4'h7:    hex7 = 7'h07;
         4'h8:    hex7 = 7'h7F;
         4'h9:    hex7 = 7'h6F;
         4'hA:    hex7 = 7'h77;
         4'hB:    hex7 = 7'h7C;
         4'hC:    hex7 = 7'h39;
         4'hD:    hex7 = 7'h5E;
         4'hE:    hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   assign slot_end  = (prescaler == PW'(CLK_DIV - 1));
   assign frame_end = slot_end && (index == IW'(NUM_DIGITS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         index     <= '0;
      end else if (slot_end) begin
         prescaler <= '0;
         index     <= (index == IW'(NUM_DIGITS - 1)) ? '0 : index + IW'(1);
      end else begin
         prescaler <= prescaler + PW'(1);
      end
   end

   // Pending absorbs every load; active only changes at the frame boundary so a frame never tears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_data <= '0;
         pending_dp   <= '0;
         active_data  <= '0;
         active_dp    <= '0;
      end else begin
         if (load) begin
            pending_data <= data_in;
            pending_dp   <= dp_in;
         end
         if (frame_end) begin
            active_data <= load ? data_in : pending_data;
            active_dp   <= load ? dp_in   : pending_dp;
         end
      end
   end

   // A digit is a leading zero when it and every digit to its left are zero.
   always_comb begin
      zero_run = 1'b1;
      lz_blank = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run    = zero_run & (active_data[i*4 +: 4] == 4'h0);
         lz_blank[i] = blank_lz & zero_run & (i != 0);
      end
   end

   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_en    = 1'b0;
      cur_blank = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (index == IW'(i)) begin
            cur_nib   = active_data[i*4 +: 4];
            cur_dp    = active_dp[i];
            cur_en    = digit_en[i];
            cur_blank = lz_blank[i];
         end
      end
   end

   // Prescaler value 0 is always dark so the previous digit's anode cannot ghost into this slot.
   always_comb begin
      on_limit  = (OW'(brightness) + OW'(1)) * OW'(STEP);
      in_window = cur_en && (prescaler != '0) && ({1'b0, prescaler} < on_limit);
      an_next   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         an_next[i] = in_window && (index == IW'(i));
      end
      seg_next = (in_window && !cur_blank) ? hex7(cur_nib) : 7'h00;
      dp_next  = in_window && cur_dp;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_out     <= {NUM_DIGITS{POL}};
         seg_out    <= {7{POL}};
         dp_out     <= POL;
         frame_tick <= 1'b0;
      end else begin
         an_out     <= an_next ^ {NUM_DIGITS{POL}};
         seg_out    <= seg_next ^ {7{POL}};
         dp_out     <= dp_next ^ POL;
         frame_tick <= frame_end;
      end
   end

endmodule

// File: tb/tb_sev_seg_scanner.sv
// Directed bench for sev_seg_scanner: 4 digits, 16-cycle slots, active-low pins.
module tb_sev_seg_scanner;

   localparam int ND = 4;
   localparam int CD = 16;
   localparam int BW = 4;

   typedef struct {
      logic [15:0]     data;
      logic [3:0]      dp;
      logic [3:0]      en;
      logic            blank;
      logic [3:0]      bright;
      logic [3:0][6:0] glyph;
      logic [3:0]      exp_dp;
      int              on_cycles;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   data_in;
   logic [3:0]    dp_in;
   logic [3:0]    digit_en;
   logic          load;
   logic          blank_lz;
   logic [3:0]    brightness;
   logic [3:0]    an_out;
   logic [6:0]    seg_out;
   logic          dp_out;
   logic          frame_tick;

   int tests = 0;
   int fails = 0;
   vec_t vecs[6];

   sev_seg_scanner #(
      .NUM_DIGITS (ND),
      .CLK_DIV    (CD),
      .BRIGHT_W   (BW),
      .ACTIVE_LOW (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .load       (load),
      .blank_lz   (blank_lz),
      .brightness (brightness),
      .an_out     (an_out),
      .seg_out    (seg_out),
      .dp_out     (dp_out),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   function automatic vec_t make_vec(input logic [15:0] d, input logic [3:0] dp,
                                     input logic [3:0] en, input logic bl,
                                     input logic [3:0] br, input logic [27:0] g,
                                     input logic [3:0] edp, input int on);
      vec_t v;
      v.data = d; v.dp = dp; v.en = en; v.blank = bl; v.bright = br;
      v.glyph = g; v.exp_dp = edp; v.on_cycles = on;
      return v;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Presents one vector and strobes load for a single cycle.
   task automatic apply_stimulus(input vec_t v);
      data_in    = v.data;
      dp_in      = v.dp;
      digit_en   = v.en;
      blank_lz   = v.blank;
      brightness = v.bright;
      load       = 1'b1;
      @(negedge clk);
      load       = 1'b0;
   endtask

   task automatic wait_tick(input string name);
      bit ok = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (frame_tick) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check_output(name, 32'd0, 32'd1);
   endtask

   // Called on the negedge where frame_tick is high; samples the 64 cycles of that frame.
   task automatic observe_frame(input vec_t v, input int vn);
      int         cnt[4];
      logic [6:0] seg_seen[4];
      logic       dp_seen[4];
      int         multi_bad = 0;
      int         idle_bad = 0;
      int         tick_bad = 0;
      for (int i = 0; i < 4; i++) begin
         cnt[i]      = 0;
         seg_seen[i] = ~v.glyph[i];
         dp_seen[i]  = ~v.exp_dp[i];
      end
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (frame_tick !== (k == 64)) tick_bad++;
         if ($countones(~an_out) > 1) multi_bad++;
         if (an_out == 4'hF) begin
            if (seg_out !== 7'h7F || dp_out !== 1'b1) idle_bad++;
         end else begin
            for (int i = 0; i < 4; i++) begin
               if (an_out[i] == 1'b0) begin
                  cnt[i]++;
                  if (seg_out !== ~v.glyph[i]) seg_seen[i] = seg_out;
                  if (dp_out !== ~v.exp_dp[i]) dp_seen[i] = dp_out;
               end
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         check_output($sformatf("v%0d_on_cycles_d%0d", vn, i), cnt[i],
                      v.en[i] ? v.on_cycles : 0);
         if (v.en[i] && v.on_cycles > 0) begin
            check_output($sformatf("v%0d_seg_d%0d", vn, i), {25'd0, seg_seen[i]},
                         {25'd0, ~v.glyph[i]});
            check_output($sformatf("v%0d_dp_d%0d", vn, i), {31'd0, dp_seen[i]},
                         {31'd0, ~v.exp_dp[i]});
         end
      end
      check_output($sformatf("v%0d_tick_spacing", vn), tick_bad, 0);
      check_output($sformatf("v%0d_one_hot", vn), multi_bad, 0);
      check_output($sformatf("v%0d_dark_when_idle", vn), idle_bad, 0);
   endtask

   initial begin
      bit found;
      vec_t byp;

      // glyphs packed {d3, d2, d1, d0}
      vecs[0] = make_vec(16'h1234, 4'b0000, 4'b1111, 1'b0, 4'hF,
                         {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000, 15);
      vecs[1] = make_vec(16'h0050, 4'b0100, 4'b1111, 1'b1, 4'h3,
                         {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0100, 3);
      vecs[2] = make_vec(16'h89AB, 4'b1001, 4'b1010, 1'b0, 4'h7,
                         {7'h7F, 7'h6F, 7'h77, 7'h7C}, 4'b1001, 7);
      vecs[3] = make_vec(16'hCDEF, 4'b1111, 4'b1111, 1'b0, 4'h0,
                         {7'h39, 7'h5E, 7'h79, 7'h71}, 4'b1111, 0);
      vecs[4] = make_vec(16'h0000, 4'b0000, 4'b1111, 1'b1, 4'h1,
                         {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000, 1);
      vecs[5] = make_vec(16'h0607, 4'b0000, 4'b1111, 1'b1, 4'hF,
                         {7'h00, 7'h7D, 7'h3F, 7'h07}, 4'b0000, 15);

      rst_n      = 1'b0;
      data_in    = '0;
      dp_in      = '0;
      digit_en   = 4'hF;
      load       = 1'b0;
      blank_lz   = 1'b0;
      brightness = 4'hF;
      #23;
      @(negedge clk);
      check_output("rst_an", {28'd0, an_out}, 32'hF);
      check_output("rst_seg", {25'd0, seg_out}, 32'h7F);
      check_output("rst_dp", {31'd0, dp_out}, 32'd1);
      check_output("rst_tick", {31'd0, frame_tick}, 32'd0);
      rst_n = 1'b1;

      // A fresh load must not reach the display before the next frame boundary.
      @(negedge clk);
      data_in = 16'h1234;
      load    = 1'b1;
      @(negedge clk);
      load    = 1'b0;
      found   = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (an_out == 4'hE) begin
            found = 1;
            break;
         end
      end
      check_output("pre_frame_d0_seen", {31'd0, found}, 32'd1);
      check_output("pre_frame_d0_seg", {25'd0, seg_out}, {25'd0, ~7'h3F});

      wait_tick("first_tick_timeout");
      for (int n = 0; n < 6; n++) begin
         apply_stimulus(vecs[n]);
         wait_tick($sformatf("v%0d_tick_timeout", n));
         observe_frame(vecs[n], n);
      end

      // Bypass: a load coinciding with the frame boundary beats the older pending value.
      byp = make_vec(16'hABCD, 4'b0000, 4'b1111, 1'b0, 4'hF,
                     {7'h77, 7'h7C, 7'h39, 7'h5E}, 4'b0000, 15);
      apply_stimulus(make_vec(16'h1111, 4'b0000, 4'b1111, 1'b0, 4'hF,
                              {7'h06, 7'h06, 7'h06, 7'h06}, 4'b0000, 15));
      repeat (62) @(negedge clk);
      data_in = 16'hABCD;
      load    = 1'b1;
      @(negedge clk);
      load    = 1'b0;
      check_output("bypass_tick", {31'd0, frame_tick}, 32'd1);
      observe_frame(byp, 6);

      // Reset in the middle of digit 1's on-window.
      repeat (18) @(negedge clk);
      check_output("mid_an_before", {28'd0, an_out}, 32'hD);
      rst_n = 1'b0;
      #1;
      check_output("mid_rst_an", {28'd0, an_out}, 32'hF);
      check_output("mid_rst_seg", {25'd0, seg_out}, 32'h7F);
      check_output("mid_rst_dp", {31'd0, dp_out}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      found = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (an_out != 4'hF) begin
            found = 1;
            break;
         end
      end
      check_output("post_rst_first_an", {28'd0, an_out}, 32'hE);
      check_output("post_rst_seen", {31'd0, found}, 32'd1);
      check_output("post_rst_seg", {25'd0, seg_out}, {25'd0, ~7'h3F});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
